// File: rtl/mul_result_accum_if.sv
// Stream bundle for the frame-sum accumulator: beat input side (s_*)
// and frame-sum output side (m_*). The slave modport is the accumulator's
// view; the master modport is the view of whatever feeds and drains it.
interface mul_result_accum_if #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 256
);
    localparam int BEATS_W = $clog2(MAX_LEN) + 1;

    logic [DATA_W-1:0]  s_tdata;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;
    logic [DATA_W-1:0]  m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tuser;
    logic [BEATS_W-1:0] m_beats;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tuser, m_beats
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tuser, m_beats
    );
endinterface

// File: rtl/mul_result_accum.sv
// Frame-sum accumulator for doubled multiplier results. Beats are summed
// with saturation until s_tlast or MAX_LEN beats close the frame; the sum,
// a sticky saturation flag and the beat count are then held until taken.
module mul_result_accum #(
    parameter int MAX_LEN = 256,
    parameter int DATA_W  = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    mul_result_accum_if.slave bus,
    output logic [15:0]       frame_cnt
);
    localparam int BEATS_W = $clog2(MAX_LEN) + 1;
    localparam logic [BEATS_W-1:0] LEN_LIMIT = BEATS_W'(MAX_LEN);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  acc_d;
    logic [DATA_W:0]    sum_d;
    logic [BEATS_W-1:0] beats_q;
    logic [BEATS_W-1:0] beats_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               close_d;
    logic [15:0]        frame_cnt_q;

    // Clamp a carry-extended sum to all ones when the carry is set. An
    // all-ones accumulator stays saturated because any non-zero addend
    // carries again and a zero addend leaves it unchanged.
    function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W:0] sum);
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    // Candidate accumulator/beat-count update for a beat offered this cycle.
    always_comb begin
        sum_d   = {1'b0, acc_q} + {1'b0, bus.s_tdata};
        acc_d   = sat_sum(sum_d);
        ovf_d   = ovf_q | sum_d[DATA_W];
        beats_d = beats_q + BEATS_W'(1);
        close_d = bus.s_tlast || (beats_d == LEN_LIMIT);
    end

    // Two-state control: accumulate beats, then hold the closed frame sum.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.s_tvalid) begin
                        acc_q   <= acc_d;
                        beats_q <= beats_d;
                        ovf_q   <= ovf_d;
                        if (close_d) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.m_tready) begin
                        acc_q       <= '0;
                        beats_q     <= '0;
                        ovf_q       <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= ACCUM;
                    end
                end
            endcase
        end
    end

    // Handshake outputs come straight from the state register so neither
    // m_tready nor s_tvalid has a combinational path to them.
    assign bus.s_tready = (state_q == ACCUM);
    assign bus.m_tvalid = (state_q == HOLD);
    assign bus.m_tdata  = acc_q;
    assign bus.m_tuser  = ovf_q;
    assign bus.m_beats  = beats_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_mul_result_accum.sv
// Bench for mul_result_accum (MAX_LEN = 4 so forced frame closure is
// reachable). A negedge monitor keeps a reference model of the frame sum;
// closed frames are queued and compared when the DUT presents them.
module tb_mul_result_accum;
    localparam int DW   = 32;
    localparam int MLEN = 4;
    localparam int BW   = $clog2(MLEN) + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic [BW-1:0] b;
    } exp_t;

    logic        aclk;
    logic        aresetn;
    logic [15:0] frame_cnt;

    mul_result_accum_if #(.DATA_W(DW), .MAX_LEN(MLEN)) bus ();

    mul_result_accum #(.MAX_LEN(MLEN), .DATA_W(DW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic rnd_rdy = 1'b0;
    logic preload = 1'b0;

    // Reference model state, owned by the monitor
    logic [DW-1:0] m_acc  = '0;
    logic          m_ovf  = 1'b0;
    int            m_cnt  = 0;
    logic          m_hold = 1'b0;
    logic [15:0]   m_fcnt = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge aclk) begin
        logic [63:0] sum;
        exp_t        e;
        if (!aresetn) begin
            check("rst_m_tvalid", bus.m_tvalid, 0);
            check("rst_s_tready", bus.s_tready, 1);
            check("rst_m_tdata",  bus.m_tdata, 0);
            check("rst_m_tuser",  bus.m_tuser, 0);
            check("rst_m_beats",  bus.m_beats, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            m_acc = '0; m_ovf = 1'b0; m_cnt = 0; m_hold = 1'b0; m_fcnt = '0;
            sb.delete();
        end else begin
            if (preload) m_fcnt = 16'hFFFF;
            check("s_tready", bus.s_tready, !m_hold);
            check("m_tvalid", bus.m_tvalid, m_hold);
            check("frame_cnt", frame_cnt, m_fcnt);
            if (m_hold) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 0, 1);
                    m_hold = 1'b0;
                end else begin
                    e = sb[0];
                    check("m_tdata", bus.m_tdata, e.d);
                    check("m_tuser", bus.m_tuser, e.u);
                    check("m_beats", bus.m_beats, e.b);
                    if (bus.m_tready) begin
                        void'(sb.pop_front());
                        m_hold = 1'b0;
                        m_fcnt = m_fcnt + 16'd1;
                    end
                end
            end else if (bus.s_tvalid) begin
                sum = 64'(m_acc) + 64'(bus.s_tdata);
                if (sum > 64'h0000_0000_FFFF_FFFF) begin
                    m_acc = '1;
                    m_ovf = 1'b1;
                end else begin
                    m_acc = sum[DW-1:0];
                end
                m_cnt++;
                if (bus.s_tlast || m_cnt == MLEN) begin
                    e.d = m_acc; e.u = m_ovf; e.b = BW'(m_cnt);
                    sb.push_back(e);
                    m_acc = '0; m_ovf = 1'b0; m_cnt = 0; m_hold = 1'b1;
                end
            end
        end
    end

    // Offer one beat and return just after the edge that accepts it
    task automatic send(input logic [DW-1:0] d, input logic l);
        int budget;
        budget = 0;
        bus.s_tdata  = d;
        bus.s_tvalid = 1'b1;
        bus.s_tlast  = l;
        forever begin
            @(negedge aclk);
            if (bus.s_tready) break;
            budget++;
            if (budget > 40) begin
                check("send_timeout", 0, 1);
                break;
            end
            @(posedge aclk); #1;
            if (rnd_rdy) bus.m_tready = (budget > 20) || ($urandom_range(0, 2) != 0);
        end
        @(posedge aclk); #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        if (rnd_rdy) bus.m_tready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic u,
                              input logic [BW-1:0] b);
        @(negedge aclk);
        check({tag, "_vld"},  bus.m_tvalid, 1);
        check({tag, "_data"}, bus.m_tdata, d);
        check({tag, "_user"}, bus.m_tuser, u);
        check({tag, "_beats"}, bus.m_beats, b);
        @(posedge aclk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn      = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b1;
        idle(3);
        aresetn = 1'b1;
        idle(1);

        // Basic frame
        send(2, 0); send(4, 0); send(6, 1);
        expect_out("basic", 12, 0, 3);
        @(negedge aclk); check("basic_fcnt", frame_cnt, 1);
        @(posedge aclk); #1;

        // Saturation, then a clean frame
        send(32'hFFFF_FFFE, 0); send(32'h0000_0004, 1);
        expect_out("sat", 32'hFFFF_FFFF, 1, 2);
        send(1, 1);
        expect_out("post_sat", 1, 0, 1);
        send(32'hFFFF_FFFF, 0); send(1, 0); send(0, 1);
        expect_out("sat_sticky", 32'hFFFF_FFFF, 1, 3);

        // s_tlast without s_tvalid is ignored
        bus.s_tlast = 1'b1; idle(2); bus.s_tlast = 1'b0;
        send(5, 1);
        expect_out("stray_last", 5, 0, 1);

        // Forced close at MAX_LEN; the fifth beat opens the next frame
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        expect_out("forced", 4, 0, 4);
        send(1, 0); send(5, 1);
        expect_out("after_forced", 6, 0, 2);

        // s_tlast on beat MAX_LEN closes exactly one frame
        send(3, 0); send(3, 0); send(3, 0); send(3, 1);
        expect_out("last_at_max", 12, 0, 4);
        idle(3);

        // Backpressure with a beat waiting
        bus.m_tready = 1'b0;
        send(10, 1);
        bus.s_tdata = 7; bus.s_tvalid = 1'b1; bus.s_tlast = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            check("bp_s_tready", bus.s_tready, 0);
            check("bp_m_tdata",  bus.m_tdata, 10);
        end
        @(posedge aclk); #1;
        bus.m_tready = 1'b1;
        send(7, 1);
        expect_out("bp_next", 7, 0, 1);

        // Reset mid-frame discards the partial sum
        send(3, 0); send(5, 0);
        aresetn = 1'b0; idle(1); aresetn = 1'b1;
        send(9, 1);
        expect_out("rst_mid", 9, 0, 1);
        @(negedge aclk); check("rst_mid_fcnt", frame_cnt, 1);
        @(posedge aclk); #1;

        // Reset while holding discards the pending sum
        bus.m_tready = 1'b0;
        send(8, 1); idle(2);
        aresetn = 1'b0; idle(1); aresetn = 1'b1;
        bus.m_tready = 1'b1;
        send(2, 1);
        expect_out("rst_hold", 2, 0, 1);
        @(negedge aclk); check("rst_hold_fcnt", frame_cnt, 1);
        @(posedge aclk); #1;

        // frame_cnt wrap
        force dut.frame_cnt_q = 16'hFFFF;
        preload = 1'b1;
        #2 release dut.frame_cnt_q;
        @(posedge aclk); #1;
        preload = 1'b0;
        send(3, 1);
        expect_out("wrap_frame", 3, 0, 1);
        @(negedge aclk); check("wrap_fcnt", frame_cnt, 0);
        @(posedge aclk); #1;

        // Random traffic with random output backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [DW-1:0] d;
            if ($urandom_range(0, 3) == 0) d = 32'hF000_0000 | $urandom;
            else d = DW'($urandom_range(0, 1000));
            send(d, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rnd_rdy = 1'b0;
        bus.m_tready = 1'b1;
        send(1, 1);
        idle(4);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mul_result_accum.md
MUL_RESULT_ACCUM -- requirements
Module: mul_result_accum

Interface
REQ-001 Parameter MAX_LEN, default 256: maximum beats per frame; a frame is forced closed at this length even without s_tlast.
REQ-002 Parameter DATA_W, default 32: width of the input beats and of the sum.
REQ-003 aclk  input  1  single clock; all state is updated on the rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 s_tdata  input  DATA_W  doubled data-path result from the upstream multiplier stage, unsigned.
REQ-006 s_tvalid  input  1  s_tdata is valid.
REQ-007 s_tlast  input  1  marks the last beat of the frame; qualified by s_tvalid.
REQ-008 s_tready  output  1  block accepts a beat.
REQ-009 m_tdata  output  DATA_W  frame sum.
REQ-010 m_tvalid  output  1  m_tdata, m_tuser and m_beats are valid.
REQ-011 m_tready  input  1  downstream accepts the sum.
REQ-012 m_tuser  output  1  saturation flag for the frame.
REQ-013 m_beats  output  clog2(MAX_LEN)+1  number of beats summed in the frame.
REQ-014 frame_cnt  output  16  count of completed output transfers; wraps from 0xFFFF to 0.

Function
REQ-015 Handshakes: a beat is accepted when s_tvalid and s_tready are both 1; an output transfer completes when m_tvalid and m_tready are both 1.
REQ-016 The block shall be a two-state FSM with states ACCUM and HOLD.
REQ-017 In ACCUM: s_tready = 1 and m_tvalid = 0.
REQ-018 In HOLD: s_tready = 0 and m_tvalid = 1.
REQ-019 ACCUM, on each accepted beat: acc <= sat(acc + s_tdata), and beats <= beats + 1.
REQ-020 The addition shall be carried out at DATA_W+1 bits.
REQ-021 If the carry bit of that addition is 1, acc shall be set to all ones and the sticky ovf flag shall be set.
REQ-022 Once saturated, acc shall remain at all ones for the rest of the frame.
REQ-023 ACCUM -> HOLD shall occur on an accepted beat with s_tlast = 1, or on an accepted beat that brings beats to MAX_LEN.
REQ-024 On that transition, the closing beat shall be included in acc, beats and ovf.
REQ-025 Latency: m_tvalid shall assert in the cycle after the closing beat is accepted.
REQ-026 In HOLD, m_tdata = acc, m_tuser = ovf and m_beats = beats, all held stable until transfer.
REQ-027 HOLD -> ACCUM shall occur on m_tready = 1.
REQ-028 On that transition: acc, beats and ovf cleared to 0, and frame_cnt incremented by 1.
REQ-029 While m_tready = 0 in HOLD, the block shall stay in HOLD indefinitely with all outputs unchanged.
REQ-030 s_tvalid asserted while in HOLD shall be ignored; no beat is consumed.
REQ-031 s_tlast asserted with s_tvalid = 0 shall have no effect.
REQ-032 A frame of length 1 (first beat has s_tlast = 1) shall produce m_beats = 1 and m_tdata = that beat.
REQ-033 s_tlast = 1 on beat MAX_LEN shall close exactly one frame; no empty frame shall be produced.
REQ-034 Zero-length frames shall never be emitted.
REQ-035 s_tready and m_tvalid shall be driven directly from the state register, with no combinational path from m_tready or s_tvalid.

Reset
REQ-036 aresetn = 0 shall immediately force: state ACCUM, acc 0, beats 0, ovf 0, frame_cnt 0.
REQ-037 During reset, outputs shall be: m_tvalid 0, s_tready 1, m_tdata 0, m_tuser 0, m_beats 0.
REQ-038 Reset asserted mid-frame or in HOLD shall discard the partial or pending sum; no output transfer occurs.
REQ-039 After aresetn deasserts, the first accepted beat shall start a new frame.

Verification
REQ-040 Basic frame: beats 2, 4, 6 with s_tlast on 6, m_tready = 1 -> one cycle later m_tvalid = 1, m_tdata = 12, m_beats = 3, m_tuser = 0; frame_cnt becomes 1.
REQ-041 Saturation: beats 0xFFFFFFFE then 0x00000004 (s_tlast) -> m_tdata = 0xFFFFFFFF, m_tuser = 1; the next frame 1 (s_tlast) -> m_tdata = 1, m_tuser = 0.
REQ-042 Forced close: MAX_LEN = 4, five beats of value 1 without s_tlast -> first output m_tdata = 4, m_beats = 4; fifth beat starts the next frame, beats = 1.
REQ-043 Backpressure: frame 10 (s_tlast), m_tready = 0 for 5 cycles with s_tvalid held 1 and s_tdata = 7 -> s_tready = 0 throughout, m_tdata stays 10; after m_tready = 1, the 7 is accepted into the new frame.
REQ-044 Reset mid-operation: accept 3, 5, then pulse aresetn low for 1 cycle, then send 9 (s_tlast) -> m_tdata = 9, m_beats = 1, frame_cnt = 1.
REQ-045 Wrap: preload 0xFFFF completed frames (or force frame_cnt), complete one more frame -> frame_cnt = 0.
